// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes and fixed-length
// vector memory holds, with saturating stall/flush event counters.
module hazard_controller #(
    parameter int unsigned R           = 4,
    parameter int unsigned VMEM_CYCLES = 4,
    parameter int unsigned CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [R-1:0]  Rs1D,
    input  logic [R-1:0]  Rs2D,
    input  logic [R-1:0]  RdE,
    input  logic          MemReadE,
    input  logic          RegWriteE,
    input  logic          PCSrcE,
    input  logic          VMemStartE,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          FlushD,
    output logic          FlushE,
    output logic          busy,
    output logic          err,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    typedef enum logic {StRun, StVmem} state_t;

    // The start cycle and the final cnt==0 cycle bracket the countdown.
    localparam logic [7:0]    VmemInit = 8'(VMEM_CYCLES - 2);
    localparam logic [CW-1:0] CntMax   = {CW{1'b1}};

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;
    logic          lw_stall;

    assign lw_stall = MemReadE & RegWriteE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        busy    = (state_q == StVmem);

        unique case (state_q)
            StRun: begin
                if (VMemStartE) begin
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    cnt_d   = VmemInit;
                    state_d = StVmem;
                    if (PCSrcE) begin
                        err_d = 1'b1;
                    end
                end else if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (lw_stall) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            StVmem: begin
                if (cnt_q != 8'd0) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    cnt_d  = cnt_q - 8'd1;
                end else begin
                    state_d = StRun;
                end
            end
        endcase

        // Reset forces a clean, flushed pipeline regardless of state.
        if (!rst) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
            busy   = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallD && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
        if (FlushD && (flush_cnt_q != CntMax)) begin
            flush_cnt_d = flush_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StRun;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign err       = err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
